// File: rtl/dsd_word_serializer_if.sv
// Word handshake between the ping-pong DSD buffer (master) and the serializer (slave).
// The master issues din/din_valid strobes and watches the registered wready.
interface dsd_word_serializer_if;
  logic [15:0] din;
  logic        din_valid;
  logic        wready;

  modport master (output din, output din_valid, input wready);
  modport slave  (input din, input din_valid, output wready);
endinterface

// File: rtl/dsd_word_serializer.sv
// DSD word serializer: 2-entry holding queue, programmable bit-clock divider and
// MSB-first shifter. Emits the SILENCE pattern when the queue runs dry while enabled.
module dsd_word_serializer #(
  parameter int unsigned DIV_W   = 8,
  parameter logic [15:0] SILENCE = 16'h6969
) (
  input  logic                 ACLK,
  input  logic                 ARST,
  dsd_word_serializer_if.slave bus,
  input  logic                 enable_i,
  input  logic [DIV_W-1:0]     rate_div_i,
  output logic                 dsd_bit_o,
  output logic                 dsd_bclk_o,
  output logic                 underrun_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam logic [15:0] SIL_W = SILENCE;

  state_e           state_q, state_d;
  logic [15:0]      mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             wready_q, wready_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] rate_q, rate_d;
  logic             bclk_q, bclk_d;
  logic             bit_q, bit_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;
  logic             busy_q;
  logic             wr_en_s;
  logic             pop_s;
  logic             tick_s;
  logic [15:0]      head_s;

  assign head_s = mem_q[rd_ptr_q];
  assign tick_s = (div_cnt_q == rate_q);

  // Queue bookkeeping: accept while not full, drop and flag when full, track occupancy.
  always_comb begin
    wr_en_s    = bus.din_valid && (count_q != 2'd2);
    overflow_d = overflow_q;
    if (bus.din_valid && (count_q == 2'd2)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    wr_ptr_d = wr_en_s ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, wr_en_s} - {1'b0, pop_s};
    wready_d = (count_d == 2'd0);
  end

  // Serializer FSM next state: divider, bit clock, shifter and word reload.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    rate_d     = rate_q;
    bclk_d     = bclk_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    underrun_d = underrun_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bclk_d    = 1'b0;
        bit_d     = 1'b0;
        div_cnt_d = '0;
        rate_d    = rate_div_i;
        if (enable_i && (count_q != 2'd0)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Bit 15 goes on the line now; the first half period starts afresh.
        shreg_d   = head_s;
        bit_d     = head_s[15];
        pop_s     = 1'b1;
        bit_cnt_d = 4'd0;
        div_cnt_d = '0;
        rate_d    = rate_div_i;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_s) begin
          div_cnt_d = '0;
          rate_d    = rate_div_i;
          bclk_d    = ~bclk_q;
          if (bclk_q) begin
            // Falling tick: present the next bit, or start the next word.
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d = 4'd0;
              if (!enable_i) begin
                state_d = ST_IDLE;
                bclk_d  = 1'b0;
                bit_d   = 1'b0;
              end else if (count_q != 2'd0) begin
                shreg_d = head_s;
                bit_d   = head_s[15];
                pop_s   = 1'b1;
              end else begin
                shreg_d    = SIL_W;
                bit_d      = SIL_W[15];
                underrun_d = 1'b1;
              end
            end else begin
              bit_d     = shreg_q[14];
              shreg_d   = {shreg_q[14:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            bit_d = bit_q;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        bclk_d  = 1'b0;
        bit_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that also flushes the queue.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q    <= ST_IDLE;
      mem_q[0]   <= 16'h0000;
      mem_q[1]   <= 16'h0000;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      wready_q   <= 1'b0;
      div_cnt_q  <= '0;
      rate_q     <= '0;
      bclk_q     <= 1'b0;
      bit_q      <= 1'b0;
      shreg_q    <= 16'h0000;
      bit_cnt_q  <= 4'd0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= bus.din;
      end
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wready_q   <= wready_d;
      div_cnt_q  <= div_cnt_d;
      rate_q     <= rate_d;
      bclk_q     <= bclk_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign bus.wready = wready_q;
  assign dsd_bit_o  = bit_q;
  assign dsd_bclk_o = bclk_q;
  assign underrun_o = underrun_q;
  assign overflow_o = overflow_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_dsd_word_serializer.sv
// Self-checking bench for dsd_word_serializer: expected bits are queued when words
// are written and checked on every rising bit clock, together with the bit period.
module tb_dsd_word_serializer;

  logic       ACLK = 1'b0;
  logic       ARST = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] rate_div = 8'd1;
  logic       dsd_bit, dsd_bclk, underrun, overflow, busy;

  dsd_word_serializer_if bus_if();

  dsd_word_serializer #(.DIV_W(8), .SILENCE(16'h6969)) dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .bus        (bus_if),
    .enable_i   (enable),
    .rate_div_i (rate_div),
    .dsd_bit_o  (dsd_bit),
    .dsd_bclk_o (dsd_bclk),
    .underrun_o (underrun),
    .overflow_o (overflow),
    .busy_o     (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  rate;
    int          period;
  } vec_t;

  vec_t vecs [3];
  logic exp_q [$];
  int   exp_period = 4;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] sil = 16'h6969;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Rising bit clock: pop one expected bit and check spacing from the previous rise.
  task automatic monitor();
    logic prev_b;
    int   cyc;
    int   last_rise;
    logic e;
    prev_b = 1'b0;
    cyc = 0;
    last_rise = -1;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (ARST || !busy) begin
        prev_b = 1'b0;
        last_rise = -1;
      end else begin
        if (dsd_bclk && !prev_b) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bit", int'(dsd_bit), int'(e));
          end
          if (last_rise >= 0) chk("bclk_period", cyc - last_rise, exp_period);
          last_rise = cyc;
        end
        prev_b = dsd_bclk;
      end
    end
  endtask

  task automatic write_word(input logic [15:0] w, input bit push);
    @(posedge ACLK);
    #1;
    bus_if.din = w;
    bus_if.din_valid = 1'b1;
    if (push) begin
      for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
    end
    @(posedge ACLK);
    #1;
    bus_if.din_valid = 1'b0;
  endtask

  task automatic push_silence();
    for (int i = 15; i >= 0; i--) exp_q.push_back(sil[i]);
  endtask

  task automatic wait_q_le(input int n, input string name);
    int k;
    k = 0;
    while ((exp_q.size() > n) && (k < 3000)) begin
      @(negedge ACLK);
      k++;
    end
    chk(name, (exp_q.size() <= n) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && (k < 2000)) begin
      @(negedge ACLK);
      k++;
    end
    chk(name, int'(busy), 0);
  endtask

  initial begin
    bus_if.din = 16'h0000;
    bus_if.din_valid = 1'b0;
    vecs[0] = '{word: 16'hA5F0, rate: 8'd1, period: 4};
    vecs[1] = '{word: 16'h8001, rate: 8'd0, period: 2};
    vecs[2] = '{word: 16'h3C5A, rate: 8'd2, period: 6};

    fork
      monitor();
    join_none

    // Reset held 3 cycles while din_valid toggles
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK);
      #1;
      bus_if.din = 16'hDEAD;
      bus_if.din_valid = ~bus_if.din_valid;
    end
    @(negedge ACLK);
    chk("rst_outputs", int'({dsd_bit, dsd_bclk, underrun, overflow, busy, bus_if.wready}), 0);
    @(posedge ACLK);
    #1;
    ARST = 1'b0;
    bus_if.din_valid = 1'b0;
    enable = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("rst_wready_after_release", int'(bus_if.wready), 1);
    repeat (10) @(negedge ACLK);
    chk("rst_no_write_accepted", int'(busy), 0);

    // Single words at several rates; enable dropped mid-word so it ends cleanly
    for (int v = 0; v < 3; v++) begin
      rate_div = vecs[v].rate;
      exp_period = vecs[v].period;
      enable = 1'b1;
      write_word(vecs[v].word, 1'b1);
      @(negedge ACLK);
      chk("lat_wready_low", int'(bus_if.wready), 0);
      chk("lat_busy_before_load", int'(busy), 0);
      @(negedge ACLK);
      chk("lat_busy_at_load", int'(busy), 1);
      chk("lat_bit_at_load", int'(dsd_bit), 0);
      @(negedge ACLK);
      chk("lat_first_bit", int'(dsd_bit), int'(vecs[v].word[15]));
      wait_q_le(8, "vec_progress");
      enable = 1'b0;
      wait_q_le(0, "vec_done");
      wait_idle("vec_idle");
      chk("vec_no_underrun", int'(underrun), 0);
      chk("vec_idle_lines", int'({dsd_bit, dsd_bclk}), 0);
    end

    // Back-to-back words, continuous stream
    rate_div = 8'd1;
    exp_period = 4;
    enable = 1'b1;
    write_word(16'hFFFF, 1'b1);
    write_word(16'h0000, 1'b1);
    wait_q_le(24, "b2b_first_word");
    chk("b2b_wready_low", int'(bus_if.wready), 0);
    wait_q_le(15, "b2b_second_loaded");
    @(negedge ACLK);
    chk("b2b_wready_high", int'(bus_if.wready), 1);
    wait_q_le(10, "b2b_progress");
    enable = 1'b0;
    wait_q_le(0, "b2b_done");
    wait_idle("b2b_idle");

    // Overflow: three writes while idle, the third is dropped
    write_word(16'h1234, 1'b1);
    write_word(16'hC0DE, 1'b1);
    @(negedge ACLK);
    chk("ovf_not_yet", int'(overflow), 0);
    write_word(16'hBEEF, 1'b0);
    @(negedge ACLK);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_wready", int'(bus_if.wready), 0);
    chk("ovf_idle", int'(busy), 0);
    enable = 1'b1;
    wait_q_le(10, "ovf_progress");
    enable = 1'b0;
    wait_q_le(0, "ovf_done");
    wait_idle("ovf_stop");
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_no_underrun", int'(underrun), 0);

    // Starvation: one word, then SILENCE fills the line
    enable = 1'b1;
    write_word(16'h0F0F, 1'b1);
    push_silence();
    wait_q_le(0, "starve_done");
    chk("starve_underrun", int'(underrun), 1);
    repeat (20) @(negedge ACLK);
    enable = 1'b0;
    wait_idle("starve_idle");
    chk("starve_underrun_sticky", int'(underrun), 1);

    // Reset in the middle of a word
    enable = 1'b1;
    write_word(16'hFFFF, 1'b1);
    wait_q_le(9, "arst_bit7");
    @(posedge ACLK);
    #1;
    ARST = 1'b1;
    exp_q.delete();
    @(posedge ACLK);
    @(negedge ACLK);
    chk("arst_bit", int'(dsd_bit), 0);
    chk("arst_bclk", int'(dsd_bclk), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_flags", int'({underrun, overflow, bus_if.wready}), 0);
    @(posedge ACLK);
    #1;
    ARST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      chk("arst_no_stale", int'({busy, dsd_bclk, dsd_bit}), 0);
    end
    rate_div = 8'd0;
    exp_period = 2;
    write_word(16'h8001, 1'b1);
    wait_q_le(6, "post_arst_progress");
    enable = 1'b0;
    wait_q_le(0, "post_arst_done");
    wait_idle("post_arst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
